// File: rtl/alu_mem_pkg.sv
// ---------------------------------------------------------------------------
// alu_mem_pkg
// Shared constants for the execute/memory slice of the ARM pipeline:
//   - OP_*  : 4-bit ARM data-processing opcodes driven on alu_control
//   - MC_*  : bit positions inside the 7-bit mem_control word
//   - WB_*  : bit positions inside the 2-bit wb_control word
//   - is_arith_op() : true for opcodes whose flags come from the adder
// ---------------------------------------------------------------------------
package alu_mem_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    // mem_control = {rd, wr, word, addr_sel, wb_sel, base_sel, swp}
    localparam int MC_SWP      = 0;
    localparam int MC_BASE_SEL = 1;
    localparam int MC_WB_SEL   = 2;
    localparam int MC_ADDR_SEL = 3;
    localparam int MC_WORD     = 4;
    localparam int MC_WR       = 5;
    localparam int MC_RD       = 6;

    // wb_control = {wr, reg_update}
    localparam int WB_REG_UPDATE = 0;
    localparam int WB_WR         = 1;

    // Arithmetic opcodes take C and V from the adder; logical ones pass them through.
    function automatic logic is_arith_op(input logic [3:0] op);
        logic arith;
        case (op)
            OP_SUB, OP_RSB, OP_ADD, OP_ADC,
            OP_SBC, OP_RSC, OP_CMP, OP_CMN: arith = 1'b1;
            default:                        arith = 1'b0;
        endcase
        return arith;
    endfunction

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Combinational 32-bit ARM ALU with NZCV flag generation.
// Ports:
//   operand1, operand2 (in, 32) : ALU operands a and b
//   carry_in           (in, 1)  : C flag / shifter carry-out
//   overflow_in        (in, 1)  : current V flag
//   alu_control        (in, 4)  : ARM data-processing opcode
//   alu_result         (out,32) : computed value (also for TST/TEQ/CMP/CMN)
//   n_flag, z_flag, c_flag, v_flag (out, 1) : flags for the result
// ---------------------------------------------------------------------------
module alu_core
    import alu_mem_pkg::*;
(
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic        carry_in,
    input  logic        overflow_in,
    input  logic [3:0]  alu_control,
    output logic [31:0] alu_result,
    output logic        n_flag,
    output logic        z_flag,
    output logic        c_flag,
    output logic        v_flag
);

    logic [31:0] add_x_s;
    logic [31:0] add_y_s;
    logic        add_cin_s;
    logic [32:0] sum_s;
    logic [31:0] logic_res_s;
    logic        arith_s;

    // Operand steering: every arithmetic op is x + y + cin, subtraction uses
    // the inverted subtrahend so the adder carry-out is the ARM "not borrow".
    always_comb begin
        add_x_s     = operand1;
        add_y_s     = operand2;
        add_cin_s   = 1'b0;
        logic_res_s = 32'h0000_0000;
        case (alu_control)
            OP_AND, OP_TST: logic_res_s = operand1 & operand2;
            OP_EOR, OP_TEQ: logic_res_s = operand1 ^ operand2;
            OP_ORR:         logic_res_s = operand1 | operand2;
            OP_MOV:         logic_res_s = operand2;
            OP_BIC:         logic_res_s = operand1 & ~operand2;
            OP_MVN:         logic_res_s = ~operand2;
            OP_SUB, OP_CMP: begin
                add_y_s   = ~operand2;
                add_cin_s = 1'b1;
            end
            OP_RSB: begin
                add_x_s   = operand2;
                add_y_s   = ~operand1;
                add_cin_s = 1'b1;
            end
            OP_ADD, OP_CMN: add_cin_s = 1'b0;
            OP_ADC:         add_cin_s = carry_in;
            OP_SBC: begin
                add_y_s   = ~operand2;
                add_cin_s = carry_in;
            end
            OP_RSC: begin
                add_x_s   = operand2;
                add_y_s   = ~operand1;
                add_cin_s = carry_in;
            end
            default: logic_res_s = 32'h0000_0000;
        endcase
    end

    // Shared 33-bit adder and result/flag selection.
    always_comb begin
        arith_s = is_arith_op(alu_control);
        sum_s   = {1'b0, add_x_s} + {1'b0, add_y_s} + {32'h0000_0000, add_cin_s};
        if (arith_s) begin
            alu_result = sum_s[31:0];
            c_flag     = sum_s[32];
            // Signed overflow: both adder inputs share a sign the result lacks.
            v_flag     = (add_x_s[31] == add_y_s[31]) && (sum_s[31] != add_x_s[31]);
        end else begin
            alu_result = logic_res_s;
            c_flag     = carry_in;
            v_flag     = overflow_in;
        end
        n_flag = alu_result[31];
        z_flag = (alu_result == 32'h0000_0000);
    end

endmodule

// File: rtl/alu_mem_stage.sv
// ---------------------------------------------------------------------------
// alu_mem_stage
// Execute/memory slice of the ARM pipeline: combinational ALU (alu_core),
// EX/MEM pipeline register, and a byte-addressed little-endian data memory.
// Produces writeback data and base-register update data for the WB stage.
//
// Parameters:
//   DMEM_BYTES : data memory size in bytes (power of two, >= 4)
//   AW         : byte-address bits used, log2(DMEM_BYTES); upper bits wrap
// Ports:
//   clock, reset            : rising-edge clock, async active-high reset
//                             (clears the pipeline register, not the memory)
//   operand1/2, carry_in, overflow_in, alu_control : ALU inputs
//   base_content_in, store_data_in : base register value, store/swap data
//   wb_add_in, base_add_in  : destination / base register numbers
//   mem_control_in          : {rd, wr, word, addr_sel, wb_sel, base_sel, swp}
//   wb_control_in           : {wr, reg_update}, passed through
//   alu_result, n/z/c/v_flag: combinational ALU outputs
//   wb_content, base_update : MEM-stage writeback and base update data
//   wb_add, base_add, wb_control : registered pass-through
// Configuration:
//   ALU_MEM_SWP_EN : when defined, mem_control bit 0 performs an atomic swap
//                    (read old data, write store data, same address).
//                    When undefined, that bit is ignored.
// ---------------------------------------------------------------------------
module alu_mem_stage
    import alu_mem_pkg::*;
#(
    parameter int DMEM_BYTES = 1024,
    parameter int AW         = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic        carry_in,
    input  logic        overflow_in,
    input  logic [3:0]  alu_control,
    input  logic [31:0] base_content_in,
    input  logic [31:0] store_data_in,
    input  logic [3:0]  wb_add_in,
    input  logic [3:0]  base_add_in,
    input  logic [6:0]  mem_control_in,
    input  logic [1:0]  wb_control_in,
    output logic [31:0] alu_result,
    output logic        n_flag,
    output logic        z_flag,
    output logic        c_flag,
    output logic        v_flag,
    output logic [31:0] wb_content,
    output logic [31:0] base_update,
    output logic [3:0]  wb_add,
    output logic [3:0]  base_add,
    output logic [1:0]  wb_control
);

    // ---------------- ALU ----------------
    alu_core u_alu_core (
        .operand1    (operand1),
        .operand2    (operand2),
        .carry_in    (carry_in),
        .overflow_in (overflow_in),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .n_flag      (n_flag),
        .z_flag      (z_flag),
        .c_flag      (c_flag),
        .v_flag      (v_flag)
    );

    // ---------------- EX/MEM pipeline register ----------------
    logic [31:0] alu_d,      alu_q;
    logic [31:0] base_d,     base_q;
    logic [31:0] store_d,    store_q;
    logic [3:0]  wb_add_d,   wb_add_q;
    logic [3:0]  base_add_d, base_add_q;
    logic [6:0]  mem_ctrl_d, mem_ctrl_q;
    logic [1:0]  wb_ctrl_d,  wb_ctrl_q;

    // Next-state of the pipeline register: plain capture every cycle.
    always_comb begin
        alu_d      = alu_result;
        base_d     = base_content_in;
        store_d    = store_data_in;
        wb_add_d   = wb_add_in;
        base_add_d = base_add_in;
        mem_ctrl_d = mem_control_in;
        wb_ctrl_d  = wb_control_in;
    end

    // Pipeline register; reset clears all fields so no read/write/writeback fires.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_q      <= 32'h0000_0000;
            base_q     <= 32'h0000_0000;
            store_q    <= 32'h0000_0000;
            wb_add_q   <= 4'h0;
            base_add_q <= 4'h0;
            mem_ctrl_q <= 7'h00;
            wb_ctrl_q  <= 2'b00;
        end else begin
            alu_q      <= alu_d;
            base_q     <= base_d;
            store_q    <= store_d;
            wb_add_q   <= wb_add_d;
            base_add_q <= base_add_d;
            mem_ctrl_q <= mem_ctrl_d;
            wb_ctrl_q  <= wb_ctrl_d;
        end
    end

    // ---------------- Swap option ----------------
    logic swp_s;
`ifdef ALU_MEM_SWP_EN
    assign swp_s = mem_ctrl_q[MC_SWP];
`else
    // Bit kept in the register for a uniform layout but has no effect.
    logic unused_swp_s;
    assign unused_swp_s = mem_ctrl_q[MC_SWP];
    assign swp_s        = 1'b0;
`endif

    // ---------------- Data memory ----------------
    logic [7:0]    mem_q [DMEM_BYTES];
    logic [AW-1:0] addr_s;
    logic [AW-1:0] w0_s, w1_s, w2_s, w3_s;
    logic          rd_en_s;
    logic          wr_en_s;
    logic [31:0]   mem_out_s;

    // Address select/truncation and effective read/write enables.
    always_comb begin
        if (mem_ctrl_q[MC_ADDR_SEL]) begin
            addr_s = base_q[AW-1:0];
        end else begin
            addr_s = alu_q[AW-1:0];
        end
        // Word accesses always use the aligned word containing addr_s.
        w0_s    = {addr_s[AW-1:2], 2'b00};
        w1_s    = {addr_s[AW-1:2], 2'b01};
        w2_s    = {addr_s[AW-1:2], 2'b10};
        w3_s    = {addr_s[AW-1:2], 2'b11};
        rd_en_s = mem_ctrl_q[MC_RD] | swp_s;
        wr_en_s = (mem_ctrl_q[MC_WR] | swp_s) & ~reset;
    end

    // Combinational read; returns pre-write data when a write is pending.
    always_comb begin
        mem_out_s = 32'h0000_0000;
        if (rd_en_s) begin
            if (mem_ctrl_q[MC_WORD]) begin
                mem_out_s = {mem_q[w3_s], mem_q[w2_s], mem_q[w1_s], mem_q[w0_s]};
            end else begin
                mem_out_s = {24'h00_0000, mem_q[addr_s]};
            end
        end else begin
            mem_out_s = 32'h0000_0000;
        end
    end

    // Memory write port; contents are not touched by reset.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            if (mem_ctrl_q[MC_WORD]) begin
                mem_q[w0_s] <= store_q[7:0];
                mem_q[w1_s] <= store_q[15:8];
                mem_q[w2_s] <= store_q[23:16];
                mem_q[w3_s] <= store_q[31:24];
            end else begin
                mem_q[addr_s] <= store_q[7:0];
            end
        end
    end

    // ---------------- MEM-stage outputs ----------------
    // Writeback and base-update muxes; a swap always returns the old memory data.
    always_comb begin
        if (swp_s || !mem_ctrl_q[MC_WB_SEL]) begin
            wb_content = mem_out_s;
        end else begin
            wb_content = alu_q;
        end
        if (mem_ctrl_q[MC_BASE_SEL]) begin
            base_update = alu_q;
        end else begin
            base_update = base_q;
        end
    end

    assign wb_add     = wb_add_q;
    assign base_add   = base_add_q;
    assign wb_control = wb_ctrl_q;

endmodule

// File: tb/tb_alu_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_mem_stage
// Self-checking bench for alu_mem_stage: directed corner cases followed by
// randomized traffic, compared against a behavioural model built from
// signed/unsigned integer arithmetic and a byte-array memory.
// ---------------------------------------------------------------------------
module tb_alu_mem_stage;
    import alu_mem_pkg::*;

    localparam logic [6:0] C_RD    = 7'b100_0000;
    localparam logic [6:0] C_WR    = 7'b010_0000;
    localparam logic [6:0] C_WORD  = 7'b001_0000;
    localparam logic [6:0] C_ASEL  = 7'b000_1000;
    localparam logic [6:0] C_WBSEL = 7'b000_0100;
    localparam logic [6:0] C_BSEL  = 7'b000_0010;
    localparam logic [6:0] C_SWP   = 7'b000_0001;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] operand1, operand2;
    logic        carry_in, overflow_in;
    logic [3:0]  alu_control;
    logic [31:0] base_content_in, store_data_in;
    logic [3:0]  wb_add_in, base_add_in;
    logic [6:0]  mem_control_in;
    logic [1:0]  wb_control_in;
    logic [31:0] alu_result;
    logic        n_flag, z_flag, c_flag, v_flag;
    logic [31:0] wb_content, base_update;
    logic [3:0]  wb_add, base_add;
    logic [1:0]  wb_control;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    alu_mem_stage #(.DMEM_BYTES(1024), .AW(10)) dut (
        .clock           (clock),
        .reset           (reset),
        .operand1        (operand1),
        .operand2        (operand2),
        .carry_in        (carry_in),
        .overflow_in     (overflow_in),
        .alu_control     (alu_control),
        .base_content_in (base_content_in),
        .store_data_in   (store_data_in),
        .wb_add_in       (wb_add_in),
        .base_add_in     (base_add_in),
        .mem_control_in  (mem_control_in),
        .wb_control_in   (wb_control_in),
        .alu_result      (alu_result),
        .n_flag          (n_flag),
        .z_flag          (z_flag),
        .c_flag          (c_flag),
        .v_flag          (v_flag),
        .wb_content      (wb_content),
        .base_update     (base_update),
        .wb_add          (wb_add),
        .base_add        (base_add),
        .wb_control      (wb_control)
    );

    // ---------------- reference model state ----------------
    typedef struct {
        logic [31:0] alu;
        logic [31:0] base;
        logic [31:0] store;
        logic [3:0]  wbadd;
        logic [3:0]  baseadd;
        logic [6:0]  mc;
        logic [1:0]  wbc;
    } stage_t;

    logic [7:0] ref_mem [1024];
    stage_t     ref_st;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic fits_s32(input longint s);
        return (s <= 64'sd2147483647) && (s >= -64'sd2147483648);
    endfunction

    // ARM semantics through wide integer arithmetic.
    task automatic ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic ci, input logic vi,
                           output logic [31:0] res, output logic cf, output logic vf);
        logic [31:0] x, y;
        logic [63:0] ux, uy, ur, extra;
        longint      sr;
        logic        arith, sub;
        arith = 1'b1; sub = 1'b0; x = a; y = b; extra = {63'd0, ci};
        res = 32'h0; cf = ci; vf = vi;
        case (op)
            4'h0, 4'h8: begin arith = 1'b0; res = a & b;  end
            4'h1, 4'h9: begin arith = 1'b0; res = a ^ b;  end
            4'hC:       begin arith = 1'b0; res = a | b;  end
            4'hD:       begin arith = 1'b0; res = b;      end
            4'hE:       begin arith = 1'b0; res = a & ~b; end
            4'hF:       begin arith = 1'b0; res = ~b;     end
            4'h2, 4'hA: begin sub = 1'b1; extra = 64'd1; end
            4'h3:       begin sub = 1'b1; extra = 64'd1; x = b; y = a; end
            4'h4, 4'hB: extra = 64'd0;
            4'h5:       extra = {63'd0, ci};
            4'h6:       sub = 1'b1;
            4'h7:       begin sub = 1'b1; x = b; y = a; end
            default:    arith = 1'b0;
        endcase
        if (arith) begin
            ux = {32'd0, x};
            uy = {32'd0, y};
            if (sub) begin
                // extra==1 means "no borrow in"; subtract the borrow otherwise
                ur  = ux - uy - (64'd1 - extra);
                res = ur[31:0];
                cf  = (ux >= uy + (64'd1 - extra));
                sr  = longint'($signed(x)) - longint'($signed(y)) - longint'(64'd1 - extra);
            end else begin
                ur  = ux + uy + extra;
                res = ur[31:0];
                cf  = (ur > 64'h0000_0000_FFFF_FFFF);
                sr  = longint'($signed(x)) + longint'($signed(y)) + longint'(extra);
            end
            vf = !fits_s32(sr);
        end
    endtask

    function automatic logic ref_swp(input stage_t s);
`ifdef ALU_MEM_SWP_EN
        return s.mc[0];
`else
        return 1'b0;
`endif
    endfunction

    function automatic int ref_addr(input stage_t s);
        return s.mc[3] ? int'(s.base % 32'd1024) : int'(s.alu % 32'd1024);
    endfunction

    function automatic logic [31:0] ref_read(input stage_t s);
        int a;
        a = ref_addr(s);
        if (!(s.mc[6] || ref_swp(s))) return 32'h0;
        if (s.mc[4]) begin
            a = a - (a % 4);
            return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
        end
        return {24'h0, ref_mem[a]};
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic vi, input logic [31:0] base,
                         input logic [31:0] st, input logic [3:0] wa, input logic [3:0] ba,
                         input logic [6:0] mc, input logic [1:0] wbc);
        alu_control = op; operand1 = a; operand2 = b; carry_in = ci; overflow_in = vi;
        base_content_in = base; store_data_in = st; wb_add_in = wa; base_add_in = ba;
        mem_control_in = mc; wb_control_in = wbc;
        #1;
    endtask

    // Compare combinational ALU and registered MEM-stage outputs with the model.
    task automatic check_pre();
        logic [31:0] r, exp_wb;
        logic        cf, vf;
        ref_alu(alu_control, operand1, operand2, carry_in, overflow_in, r, cf, vf);
        check_eq("alu_result", alu_result, r);
        check_eq("n_flag", {31'd0, n_flag}, {31'd0, r[31]});
        check_eq("z_flag", {31'd0, z_flag}, {31'd0, (r == 32'h0)});
        check_eq("c_flag", {31'd0, c_flag}, {31'd0, cf});
        check_eq("v_flag", {31'd0, v_flag}, {31'd0, vf});
        exp_wb = (ref_swp(ref_st) || !ref_st.mc[2]) ? ref_read(ref_st) : ref_st.alu;
        check_eq("wb_content", wb_content, exp_wb);
        check_eq("base_update", base_update, ref_st.mc[1] ? ref_st.alu : ref_st.base);
        check_eq("wb_add", {28'd0, wb_add}, {28'd0, ref_st.wbadd});
        check_eq("base_add", {28'd0, base_add}, {28'd0, ref_st.baseadd});
        check_eq("wb_control", {30'd0, wb_control}, {30'd0, ref_st.wbc});
    endtask

    // Clock edge: model writes memory from the old stage, then captures inputs.
    task automatic tick();
        logic [31:0] r;
        logic        cf, vf;
        int          a;
        ref_alu(alu_control, operand1, operand2, carry_in, overflow_in, r, cf, vf);
        @(posedge clock);
        if (ref_st.mc[5] || ref_swp(ref_st)) begin
            a = ref_addr(ref_st);
            if (ref_st.mc[4]) begin
                a = a - (a % 4);
                ref_mem[a]   = ref_st.store[7:0];
                ref_mem[a+1] = ref_st.store[15:8];
                ref_mem[a+2] = ref_st.store[23:16];
                ref_mem[a+3] = ref_st.store[31:24];
            end else begin
                ref_mem[a] = ref_st.store[7:0];
            end
        end
        ref_st.alu = r; ref_st.base = base_content_in; ref_st.store = store_data_in;
        ref_st.wbadd = wb_add_in; ref_st.baseadd = base_add_in;
        ref_st.mc = mem_control_in; ref_st.wbc = wb_control_in;
        #1;
    endtask

    task automatic clear_stage();
        ref_st.alu = 32'h0; ref_st.base = 32'h0; ref_st.store = 32'h0;
        ref_st.wbadd = 4'h0; ref_st.baseadd = 4'h0; ref_st.mc = 7'h0; ref_st.wbc = 2'b00;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        clear_stage();
        reset = 1'b1;
        drive(OP_AND, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 7'h00, 2'b00);
        check_eq("rst_wb_control", {30'd0, wb_control}, 32'h0);
        check_eq("rst_wb_add", {28'd0, wb_add}, 32'h0);
        check_eq("rst_wb_content", wb_content, 32'h0);
        check_eq("rst_base_update", base_update, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // ADD overflow into the sign bit
        drive(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 7'h00, 2'b00);
        check_eq("add_res", alu_result, 32'h8000_0000);
        check_eq("add_nzcv", {28'd0, n_flag, z_flag, c_flag, v_flag}, 32'h9);
        check_pre(); tick();
        // SUB 5-5
        drive(OP_SUB, 32'h5, 32'h5, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 7'h00, 2'b00);
        check_eq("sub_zero_res", alu_result, 32'h0);
        check_eq("sub_zero_zc", {30'd0, z_flag, c_flag}, 32'h3);
        check_pre(); tick();
        // SUB 0-1
        drive(OP_SUB, 32'h0, 32'h1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 7'h00, 2'b00);
        check_eq("sub_neg_res", alu_result, 32'hFFFF_FFFF);
        check_eq("sub_neg_nc", {30'd0, n_flag, c_flag}, 32'h2);
        check_pre(); tick();

        // Word store then byte and word loads
        drive(OP_MOV, 32'h0, 32'h10, 1'b0, 1'b0, 32'h0, 32'hA1B2_C3D4, 4'h1, 4'h2, C_WR | C_WORD, 2'b00);
        check_pre(); tick();
        drive(OP_MOV, 32'h0, 32'h11, 1'b0, 1'b0, 32'h0, 32'h0, 4'h1, 4'h2, C_RD, 2'b10);
        check_pre(); tick();
        check_eq("ld_byte_11", wb_content, 32'h0000_00C3);
        drive(OP_MOV, 32'h0, 32'h12, 1'b0, 1'b0, 32'h0, 32'h0, 4'h1, 4'h2, C_RD | C_WORD, 2'b10);
        check_pre(); tick();
        check_eq("ld_word_12", wb_content, 32'hA1B2_C3D4);

        // Base-addressed access with base update from the ALU
        drive(OP_MOV, 32'h0, 32'h20, 1'b0, 1'b0, 32'h0, 32'hCAFE_F00D, 4'h0, 4'h0, C_WR | C_WORD, 2'b00);
        check_pre(); tick();
        drive(OP_MOV, 32'h0, 32'h24, 1'b0, 1'b0, 32'h20, 32'h0, 4'h3, 4'h5,
              C_RD | C_WORD | C_ASEL | C_BSEL, 2'b11);
        check_pre(); tick();
        check_eq("base_ld", wb_content, 32'hCAFE_F00D);
        check_eq("base_upd", base_update, 32'h24);
        check_eq("base_wbc", {30'd0, wb_control}, 32'h3);

        // Reset asserted while a byte store sits in the pipeline register
        drive(OP_MOV, 32'h0, 32'h30, 1'b0, 1'b0, 32'h0, 32'h5A, 4'h7, 4'h6, C_WR | C_WBSEL, 2'b11);
        check_pre(); tick();
        #2;
        reset = 1'b1;
        #1;
        check_eq("midrst_wb_control", {30'd0, wb_control}, 32'h0);
        check_eq("midrst_wb_add", {28'd0, wb_add}, 32'h0);
        check_eq("midrst_wb_content", wb_content, 32'h0);
        check_eq("midrst_base_update", base_update, 32'h0);
        clear_stage();
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(OP_MOV, 32'h0, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, C_RD, 2'b00);
        check_pre(); tick();
        check_eq("midrst_mem_kept", wb_content, 32'h0);

`ifdef ALU_MEM_SWP_EN
        drive(OP_MOV, 32'h0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h11, 4'h0, 4'h0, C_WR | C_WORD, 2'b00);
        check_pre(); tick();
        drive(OP_MOV, 32'h0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h55, 4'h0, 4'h0, C_SWP | C_WORD | C_WBSEL, 2'b10);
        check_pre(); tick();
        check_eq("swp_old", wb_content, 32'h11);
        drive(OP_MOV, 32'h0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, C_RD | C_WORD, 2'b00);
        check_pre(); tick();
        check_eq("swp_new", wb_content, 32'h55);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom_range(0, 15)), pick(), pick(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 127)) : $urandom,
                  $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  7'($urandom_range(0, 127)), 2'($urandom_range(0, 3)));
            check_pre();
            tick();
        end
        drive(OP_AND, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 7'h00, 2'b00);
        check_pre();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
